// File: rtl/tick_timer_if.sv
// Control/status bundle for tick_timer: the master drives the controls, the slave
// (the timer) returns the tick, busy flag and counters.
interface tick_timer_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic             start;
  logic             stop;
  logic             mode;
  logic             period_load;
  logic [WIDTH-1:0] period_in;
  logic             tick;
  logic             busy;
  logic [WIDTH-1:0] count;
  logic [CNT_W-1:0] tick_count;

  modport master (
    output start, stop, mode, period_load, period_in,
    input  tick, busy, count, tick_count
  );

  modport slave (
    input  start, stop, mode, period_load, period_in,
    output tick, busy, count, tick_count
  );
endinterface

// File: rtl/tick_timer.sv
// Programmable periodic/one-shot tick generator used as the LFU aging time base.
// Optional prescaler enabled by defining TICK_TIMER_PRESCALE_EN.
module tick_timer #(
  parameter int WIDTH          = 32,
  parameter int DEFAULT_PERIOD = 24999999,
  parameter int CNT_W          = 16,
  parameter int PRESCALE       = 1
) (
  input  logic         clock,
  input  logic         rst,
  tick_timer_if.slave  bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic logic [WIDTH-1:0] clamp_period(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] r;
    if (x == {WIDTH{1'b0}}) begin
      r = WIDTH'(1);
    end else begin
      r = x;
    end
    return r;
  endfunction

  localparam logic [WIDTH-1:0] RST_PERIOD = clamp_period(WIDTH'(DEFAULT_PERIOD));

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] p_active_q, p_active_d;
  logic [WIDTH-1:0] p_pending_q, p_pending_d;
  logic [CNT_W-1:0] tick_count_q, tick_count_d;
  logic             tick_q, tick_d;
  logic             mode_q, mode_d;
  logic             step_s;

`ifdef TICK_TIMER_PRESCALE_EN
  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  logic [PRE_W-1:0] pre_q, pre_d;

  // Prescaler: counting advances only on the last prescaler phase.
  always_comb begin
    step_s = (pre_q == PRE_W'(PRESCALE - 1));
    if (bus.stop || bus.start) begin
      pre_d = {PRE_W{1'b0}};
    end else if (state_q == RUN) begin
      if (step_s) begin
        pre_d = {PRE_W{1'b0}};
      end else begin
        pre_d = pre_q + PRE_W'(1);
      end
    end else begin
      pre_d = {PRE_W{1'b0}};
    end
  end

  // Prescaler register.
  always_ff @(posedge clock) begin
    if (rst) begin
      pre_q <= {PRE_W{1'b0}};
    end else begin
      pre_q <= pre_d;
    end
  end
`else
  assign step_s = 1'b1;
`endif

  // Next-state logic; stop outranks start, start outranks counting.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    tick_d       = 1'b0;
    tick_count_d = tick_count_q;
    p_active_d   = p_active_q;
    mode_d       = mode_q;
    if (bus.period_load) begin
      p_pending_d = clamp_period(bus.period_in);
    end else begin
      p_pending_d = p_pending_q;
    end

    if (bus.stop) begin
      state_d = IDLE;
      count_d = {WIDTH{1'b0}};
    end else if (bus.start) begin
      state_d      = RUN;
      count_d      = {WIDTH{1'b0}};
      tick_count_d = {CNT_W{1'b0}};
      mode_d       = bus.mode;
      if (bus.period_load) begin
        p_active_d = clamp_period(bus.period_in);
      end else begin
        p_active_d = p_pending_q;
      end
    end else begin
      case (state_q)
        RUN: begin
          if (step_s) begin
            if (count_q == p_active_q - WIDTH'(1)) begin
              // Wrap: the pending period takes effect only here or on start.
              count_d    = {WIDTH{1'b0}};
              tick_d     = 1'b1;
              p_active_d = p_pending_q;
              if (tick_count_q != {CNT_W{1'b1}}) begin
                tick_count_d = tick_count_q + CNT_W'(1);
              end else begin
                tick_count_d = tick_count_q;
              end
              if (mode_q) begin
                state_d = IDLE;
              end else begin
                state_d = RUN;
              end
            end else begin
              count_d = count_q + WIDTH'(1);
            end
          end else begin
            count_d = count_q;
          end
        end
        IDLE: begin
          count_d = {WIDTH{1'b0}};
        end
        default: begin
          state_d = IDLE;
          count_d = {WIDTH{1'b0}};
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q      <= IDLE;
      count_q      <= {WIDTH{1'b0}};
      tick_q       <= 1'b0;
      tick_count_q <= {CNT_W{1'b0}};
      p_active_q   <= RST_PERIOD;
      p_pending_q  <= RST_PERIOD;
      mode_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      tick_q       <= tick_d;
      tick_count_q <= tick_count_d;
      p_active_q   <= p_active_d;
      p_pending_q  <= p_pending_d;
      mode_q       <= mode_d;
    end
  end

  assign bus.tick       = tick_q;
  assign bus.busy       = (state_q == RUN);
  assign bus.count      = count_q;
  assign bus.tick_count = tick_count_q;

endmodule

// File: tb/tb_tick_timer.sv
// Directed bench for tick_timer (DEFAULT_PERIOD=5, CNT_W=4) with hand-computed expectations.
module tb_tick_timer;
  localparam int WIDTH = 32;
  localparam int CNT_W = 4;

  logic clock;
  logic rst;
  int   vectors;
  int   miscompares;

  tick_timer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  tick_timer #(
    .WIDTH(WIDTH), .DEFAULT_PERIOD(5), .CNT_W(CNT_W), .PRESCALE(1)
  ) dut (
    .clock(clock),
    .rst  (rst),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      $error("miscompare on %s", tag);
    end
  endtask

  task automatic chk_all(input string tag, input logic t, input logic b, input int c);
    chk({tag, ".tick"}, 64'(bus.tick), 64'(t));
    chk({tag, ".busy"}, 64'(bus.busy), 64'(b));
    chk({tag, ".count"}, 64'(bus.count), 64'(c));
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.mode = 1'b0;
    bus.period_load = 1'b0;
    bus.period_in = 32'd0;
    step();
    step();
    rst = 1'b0;
    chk_all("reset", 1'b0, 1'b0, 0);
    chk("reset.tick_count", 64'(bus.tick_count), 64'd0);

    // 1: default period 5, periodic
    bus.start = 1'b1; bus.mode = 1'b0;
    step();
    bus.start = 1'b0;
    chk_all("t1.e0", 1'b0, 1'b1, 0);
    for (int k = 1; k <= 15; k++) begin
      step();
      chk_all("t1", (k % 5) == 0, 1'b1, k % 5);
    end
    chk("t1.tick_count", 64'(bus.tick_count), 64'd3);

    // 2: one-shot with P=3
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    chk_all("t2.stop", 1'b0, 1'b0, 0);
    chk("t2.tc_hold", 64'(bus.tick_count), 64'd3);
    bus.period_load = 1'b1; bus.period_in = 32'd3;
    step();
    bus.period_load = 1'b0;
    bus.start = 1'b1; bus.mode = 1'b1;
    step();
    bus.start = 1'b0; bus.mode = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      chk_all("t2", k == 3, k < 3, (k < 3) ? k : 0);
    end
    chk("t2.tick_count", 64'(bus.tick_count), 64'd1);

    // 3: P=4 running, load 8 at edge 2
    bus.period_load = 1'b1; bus.period_in = 32'd4;
    step();
    bus.period_load = 1'b0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (k == 2) begin
        bus.period_load = 1'b1; bus.period_in = 32'd8;
      end
      step();
      bus.period_load = 1'b0;
      chk_all("t3", (k == 4) || (k == 12) || (k == 20), 1'b1, (k < 4) ? k : (k - 4) % 8);
    end

    // 4: start+stop together, then start and restart with P=4
    bus.start = 1'b1; bus.stop = 1'b1;
    step();
    bus.start = 1'b0; bus.stop = 1'b0;
    chk_all("t4.both", 1'b0, 1'b0, 0);
    bus.period_load = 1'b1; bus.period_in = 32'd4;
    step();
    bus.period_load = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_all("t4.idle", 1'b0, 1'b0, 0);
    end
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (k == 2) bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      chk_all("t4", k == 6, 1'b1, (k < 2) ? k : (k - 2) % 4);
    end
    chk("t4.tick_count", 64'(bus.tick_count), 64'd1);

    // 5: period 0 clamps to 1, tick_count saturates at 15
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    bus.period_load = 1'b1; bus.period_in = 32'd0;
    step();
    bus.period_load = 1'b0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      chk_all("t5", 1'b1, 1'b1, 0);
      chk("t5.tick_count", 64'(bus.tick_count), 64'((k > 15) ? 15 : k));
    end

    // 6: reset mid-run restores the default period
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    bus.start = 1'b1; bus.period_load = 1'b1; bus.period_in = 32'd10;
    step();
    bus.start = 1'b0; bus.period_load = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      if (k == 3) begin
        bus.period_load = 1'b1; bus.period_in = 32'd3;
      end
      step();
      bus.period_load = 1'b0;
      chk_all("t6.run", 1'b0, 1'b1, k);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_all("t6.rst", 1'b0, 1'b0, 0);
    chk("t6.rst_tc", 64'(bus.tick_count), 64'd0);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk_all("t6.dflt", k == 5, 1'b1, k % 5);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
